// File: rtl/reg_pkg.sv
// Shared types and constants for the valid/ready skid register slice.
package reg_pkg;

  // Occupancy states: no beat, main register only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Number of beats the slice can hold (main + skid).
  localparam int SKID_DEPTH = 2;

  // Width of the occupancy count, wide enough for 0..SKID_DEPTH.
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  // Map occupancy state to stored-beat count.
  function automatic logic [CNT_W-1:0] state_count(input skid_state_t s);
    case (s)
      BUSY:    state_count = CNT_W'(1);
      FULL:    state_count = CNT_W'(2);
      default: state_count = '0;
    endcase
  endfunction

endpackage

// File: rtl/reg_skid_slice.sv
// Full-throughput valid/ready register slice. Both the forward path
// (valid/data) and the backward path (ready) come straight from flops, so
// neither side sees a combinational path through this stage. A skid register
// catches the one beat already in flight when the consumer drops ready.
module reg_skid_slice
  import reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [CNT_W-1:0]  count_o
);

  skid_state_t       state, state_nxt;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              main_en, main_from_skid, skid_en;
  logic              push, pop;

  // Ready/valid/count are pure decodes of the state flop.
  assign s_ready_o = (state != FULL);
  assign m_valid_o = (state != EMPTY);
  assign count_o   = state_count(state);
  assign m_data_o  = main_q;

  assign push = s_valid_i & s_ready_o;
  assign pop  = m_valid_o & m_ready_i;

  // Next-state and register-enable decode; flush overrides any handshake.
  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = BUSY;
            main_en   = 1'b1;
          end
        end
        BUSY: begin
          if (push && pop) begin
            main_en = 1'b1;
          end else if (push) begin
            state_nxt = FULL;
            skid_en   = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // s_ready_o is low here, so only a pop can occur.
          if (pop) begin
            state_nxt      = BUSY;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= EMPTY;
    else          state <= state_nxt;
  end

  // Main register: head of the queue, drives m_data_o directly.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     main_q <= '0;
    else if (main_en) main_q <= main_from_skid ? skid_q : s_data_i;
  end

  // Skid register: holds the second beat while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     skid_q <= '0;
    else if (skid_en) skid_q <= s_data_i;
  end

endmodule

// File: tb/tb_reg_skid_slice.sv
// Directed and random checks of reg_skid_slice against hand-computed values
// and a queue scoreboard.
module tb_reg_skid_slice;

  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              s_valid_i = 1'b0;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_data_i = '0;
  logic              m_valid_o;
  logic              m_ready_i = 1'b0;
  logic [DATA_W-1:0] m_data_o;
  logic [1:0]        count_o;

  int checks = 0;
  int failures = 0;

  reg_skid_slice #(.DATA_W(DATA_W)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .flush_i   (flush_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .count_o   (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    s_valid_i = v;
    s_data_i  = d;
    m_ready_i = r;
  endtask

  logic [31:0] q[$];
  logic        v, r, f, push, pop;
  logic        hold_prev;
  logic [31:0] data_prev;
  logic [31:0] exp_head;

  initial begin
    // Reset state while held in reset.
    #2;
    chk("rst_mvalid", 32'(m_valid_o), 32'd0);
    chk("rst_sready", 32'(s_ready_o), 32'd1);
    chk("rst_count",  32'(count_o),   32'd0);
    chk("rst_mdata",  m_data_o,       32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();
    chk("idle_mvalid", 32'(m_valid_o), 32'd0);
    chk("idle_count",  32'(count_o),   32'd0);

    // Streaming with ready high: one-cycle latency, count stays at 1.
    drive(1, 32'h11, 1); step();
    chk("s1_data", m_data_o, 32'h11); chk("s1_valid", 32'(m_valid_o), 32'd1);
    chk("s1_count", 32'(count_o), 32'd1); chk("s1_sready", 32'(s_ready_o), 32'd1);
    drive(1, 32'h22, 1); step();
    chk("s2_data", m_data_o, 32'h22); chk("s2_count", 32'(count_o), 32'd1);
    chk("s2_sready", 32'(s_ready_o), 32'd1);
    drive(1, 32'h33, 1); step();
    chk("s3_data", m_data_o, 32'h33); chk("s3_count", 32'(count_o), 32'd1);
    drive(0, 32'h0, 1); step();
    chk("s_drain_valid", 32'(m_valid_o), 32'd0); chk("s_drain_count", 32'(count_o), 32'd0);

    // Backpressure fills the skid, then drains in order.
    drive(1, 32'hA0, 0); step();
    chk("bp1_count", 32'(count_o), 32'd1);
    drive(1, 32'hA1, 0); step();
    chk("bp2_count", 32'(count_o), 32'd2); chk("bp2_sready", 32'(s_ready_o), 32'd0);
    chk("bp2_data", m_data_o, 32'hA0);
    drive(0, 32'h0, 0); step();
    chk("bp_hold_data", m_data_o, 32'hA0); chk("bp_hold_count", 32'(count_o), 32'd2);
    drive(0, 32'h0, 1); step();
    chk("bp_pop1_data", m_data_o, 32'hA1); chk("bp_pop1_sready", 32'(s_ready_o), 32'd1);
    chk("bp_pop1_count", 32'(count_o), 32'd1);
    step();
    chk("bp_pop2_valid", 32'(m_valid_o), 32'd0);

    // Flush from FULL drops both beats and the concurrent push.
    drive(1, 32'hB0, 0); step();
    drive(1, 32'hB1, 0); step();
    chk("fl_full_count", 32'(count_o), 32'd2);
    drive(1, 32'hBF, 1); flush_i = 1'b1; step();
    flush_i = 1'b0;
    chk("fl_count", 32'(count_o), 32'd0); chk("fl_valid", 32'(m_valid_o), 32'd0);
    drive(0, 32'h0, 1); step();
    chk("fl_after_valid", 32'(m_valid_o), 32'd0); chk("fl_after_count", 32'(count_o), 32'd0);

    // BUSY with simultaneous push and pop replaces main in place.
    drive(1, 32'hC0, 0); step();
    chk("c_busy_data", m_data_o, 32'hC0);
    drive(1, 32'hC1, 1); step();
    chk("c_pp_data", m_data_o, 32'hC1); chk("c_pp_count", 32'(count_o), 32'd1);
    drive(0, 32'h0, 1); step();
    chk("c_drain_valid", 32'(m_valid_o), 32'd0);

    // Asynchronous reset mid-transfer clears outputs without a clock edge.
    drive(1, 32'hD0, 0); step();
    drive(1, 32'hD1, 0); step();
    #2 rst_n_i = 1'b0;
    #1;
    chk("ar_valid", 32'(m_valid_o), 32'd0); chk("ar_sready", 32'(s_ready_o), 32'd1);
    chk("ar_count", 32'(count_o), 32'd0); chk("ar_data", m_data_o, 32'h0);
    drive(0, 32'h0, 0);
    #1 rst_n_i = 1'b1;
    step();
    chk("ar_after_valid", 32'(m_valid_o), 32'd0);

    // Random traffic against a queue scoreboard.
    q.delete();
    hold_prev = 1'b0;
    data_prev = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      chk("rnd_count", 32'(count_o), 32'(q.size()));
      chk("rnd_valid", 32'(m_valid_o), 32'(q.size() != 0));
      chk("rnd_sready", 32'(s_ready_o), 32'(q.size() < 2));
      if (q.size() != 0) begin
        exp_head = q[0];
        chk("rnd_head", m_data_o, exp_head);
      end
      if (hold_prev) begin
        chk("rnd_stable_valid", 32'(m_valid_o), 32'd1);
        chk("rnd_stable_data", m_data_o, data_prev);
      end
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 55);
      f = ($urandom_range(0, 999) < 5);
      drive(v, $urandom, r);
      flush_i = f;
      push = v && (q.size() < 2);
      pop  = r && (q.size() != 0);
      hold_prev = (q.size() != 0) && !r && !f;
      data_prev = m_data_o;
      if (f) begin
        q.delete();
      end else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(s_data_i);
      end
      step();
    end
    flush_i = 1'b0;
    drive(0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
